app_spi_master: RTL and testbench

OPB-mapped SPI master (mode 0, MSB first) that generates the application FPGA SPI pins: SCLK, two chip selects and two MOSI lines. It sits directly upstream of the APP2HW_IF pin stage: its outputs drive that block's APP_FPGA_SPI_* inputs, and it receives the returned MISO lines. Software loads TX data, selects a device and length, starts the transfer, and polls or takes an interrupt to collect RX data.

---
 rtl/app_spi_master_if.sv | 10 +
 rtl/app_spi_master.sv | 101 ++++++++++
 tb/tb_app_spi_master.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/app_spi_master_if.sv
// app_spi_master_if: OPB register bus between the host and app_spi_master
interface app_spi_master_if #(parameter int DATA_WIDTH = 32);
    logic [DATA_WIDTH-1:0] OPB_DI;
    logic [DATA_WIDTH-1:0] OPB_DO;
    logic [31:0] OPB_ADDR;
    logic APP_RE;
    logic APP_WE;
    modport master (output OPB_DI, OPB_ADDR, APP_RE, APP_WE, input OPB_DO);
    modport slave (input OPB_DI, OPB_ADDR, APP_RE, APP_WE, output OPB_DO);
endinterface

// File: rtl/app_spi_master.sv
// app_spi_master: OPB-mapped mode-0 SPI master; APP_SPI_LOOPBACK_EN enables CTRL.LOOPBACK
module app_spi_master #(
    parameter int DATA_WIDTH = 32,
    parameter logic [7:0] DIV_RESET = 8'd4
) (
    input  logic OPB_CLK,
    input  logic OPB_RST,
    app_spi_master_if.slave bus,
    output logic SPI_CLK,
    output logic SPI0_CS_N,
    output logic SPI1_CS_N,
    output logic SPI0_MOSI,
    output logic SPI1_MOSI,
    input  logic SPI0_MISO,
    input  logic SPI1_MISO,
    output logic IRQ
);
    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_t;
    state_t state, nxt;
    logic cs_sel, irq_en, loopback, done, overrun, act_sel;
    logic [7:0] div, act_div, cnt;
    logic [4:0] len_m1, idx;
    logic [DATA_WIDTH-1:0] txdata, rxdata, tx_lat, rx_sh, rd_data;
    logic busy, pe, ctrl_we, tx_we, st_we, start, mosi, miso;
    logic [1:0] a;
    logic unused_bits;
    assign a = bus.OPB_ADDR[3:2];
    assign busy = state != IDLE;
    assign pe = cnt == act_div;
    assign ctrl_we = bus.APP_WE && a == 2'd0;
    assign tx_we = bus.APP_WE && a == 2'd1;
    assign st_we = bus.APP_WE && a == 2'd3;
    assign start = ctrl_we && bus.OPB_DI[0] && !busy;
    assign mosi = tx_lat[idx];
    assign unused_bits = ^{bus.OPB_ADDR[31:4], bus.OPB_ADDR[1:0], bus.OPB_DI[31:21], bus.OPB_DI[7:3]};
`ifdef APP_SPI_LOOPBACK_EN
    assign miso = loopback ? mosi : (act_sel ? SPI1_MISO : SPI0_MISO);
    always_ff @(posedge OPB_CLK) begin
        if (OPB_RST) loopback <= 1'b0;
        else if (ctrl_we) loopback <= bus.OPB_DI[3];
    end
`else
    assign loopback = 1'b0;
    assign miso = act_sel ? SPI1_MISO : SPI0_MISO;
`endif
    always_ff @(posedge OPB_CLK) begin
        if (OPB_RST) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:  nxt = start ? SETUP : IDLE;
            SETUP: nxt = pe ? HIGH : SETUP;
            HIGH:  nxt = pe ? (idx == 5'd0 ? HOLD : LOW) : HIGH;
            LOW:   nxt = pe ? HIGH : LOW;
            HOLD:  nxt = pe ? IDLE : HOLD;
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        SPI_CLK = state == HIGH;
        SPI0_CS_N = !(busy && !act_sel);
        SPI1_CS_N = !(busy && act_sel);
        SPI0_MOSI = busy && !act_sel && mosi;
        SPI1_MOSI = busy && act_sel && mosi;
    end
    always_comb begin
        rd_data = a == 2'd0 ? {11'b0, len_m1, div, 4'b0, loopback, irq_en, cs_sel, 1'b0} :
                  a == 2'd1 ? txdata :
                  a == 2'd2 ? rxdata : {29'b0, overrun, done, busy};
    end
    always_ff @(posedge OPB_CLK) begin
        if (OPB_RST) begin
            {cs_sel, irq_en, done, overrun, IRQ, act_sel} <= '0;
            div <= DIV_RESET;
            len_m1 <= '0;
            {txdata, rxdata, tx_lat, rx_sh, bus.OPB_DO} <= '0;
            {act_div, cnt, idx} <= '0;
        end else begin
            if (ctrl_we) {len_m1, div, irq_en, cs_sel} <= {bus.OPB_DI[20:16], bus.OPB_DI[15:8], bus.OPB_DI[2:1]};
            if (tx_we && !busy) txdata <= bus.OPB_DI;
            overrun <= (busy && ((ctrl_we && bus.OPB_DI[0]) || tx_we)) || (overrun && !(st_we && bus.OPB_DI[2]));
            done <= (state == HOLD && pe) || (!start && done && !(st_we && bus.OPB_DI[1]));
            IRQ <= done && irq_en;
            if (bus.APP_RE && !bus.APP_WE) bus.OPB_DO <= rd_data;
            cnt <= (state != nxt || !busy) ? 8'd0 : cnt + 8'd1;
            // Transfer parameters come from the START write itself, TX from the register
            if (start) begin
                act_sel <= bus.OPB_DI[1];
                act_div <= bus.OPB_DI[15:8];
                idx <= bus.OPB_DI[20:16];
                tx_lat <= txdata;
                rx_sh <= '0;
            end
            if (nxt == HIGH && state != HIGH) rx_sh <= {rx_sh[DATA_WIDTH-2:0], miso};
            if (state == HIGH && pe && idx != 5'd0) idx <= idx - 5'd1;
            if (state == HOLD && pe) rxdata <= rx_sh;
        end
    end
endmodule

// File: tb/tb_app_spi_master.sv
// tb_app_spi_master: directed vector bench for app_spi_master with an SPI slave model
module tb_app_spi_master;
    typedef struct {
        logic [7:0] div;
        logic sel;
        logic lb;
        int n;
        logic [31:0] tx;
        logic [31:0] slave;
        logic [31:0] exp_rx;
        int exp_busy;
        logic [31:0] exp_mosi;
    } vec_t;
`ifdef APP_SPI_LOOPBACK_EN
    localparam logic [31:0] LB_RX = 32'h5A;
`else
    localparam logic [31:0] LB_RX = 32'h0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic spi_clk, cs0_n, cs1_n, mosi0, mosi1, miso0, miso1, irq, miso_val;
    logic sel = 1'b0;
    logic [31:0] slave_word = '0, mosi_cap = '0, d;
    int slave_len = 1, sc = 0, viol = 0, n_cmp = 0, n_bad = 0, cyc;
    vec_t vecs[6];
    app_spi_master_if bus();
    app_spi_master dut (
        .OPB_CLK(clk), .OPB_RST(rst), .bus(bus.slave), .SPI_CLK(spi_clk),
        .SPI0_CS_N(cs0_n), .SPI1_CS_N(cs1_n), .SPI0_MOSI(mosi0), .SPI1_MOSI(mosi1),
        .SPI0_MISO(miso0), .SPI1_MISO(miso1), .IRQ(irq)
    );
    always #5 clk = ~clk;
    assign miso_val = (sc < slave_len) ? slave_word[5'(slave_len - 1 - sc)] : 1'b0;
    assign miso0 = !sel && miso_val;
    assign miso1 = sel && miso_val;
    always @(posedge spi_clk) begin
        mosi_cap = {mosi_cap[30:0], sel ? mosi1 : mosi0};
        sc = sc + 1;
    end
    always @(negedge clk)
        if (sel ? (cs0_n !== 1'b1 || mosi0 !== 1'b0) : (cs1_n !== 1'b1 || mosi1 !== 1'b0)) viol = viol + 1;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic wr(input logic [1:0] r, input logic [31:0] v);
        bus.OPB_ADDR = {28'b0, r, 2'b0};
        bus.OPB_DI = v;
        bus.APP_WE = 1'b1;
        @(negedge clk);
        bus.APP_WE = 1'b0;
    endtask
    task automatic rd(input logic [1:0] r, output logic [31:0] v);
        bus.OPB_ADDR = {28'b0, r, 2'b0};
        bus.APP_RE = 1'b1;
        @(negedge clk);
        bus.APP_RE = 1'b0;
        v = bus.OPB_DO;
    endtask
    task automatic wait_idle(output int c);
        c = 0;
        while ((sel ? cs1_n : cs0_n) === 1'b0 && c < 2000) begin
            c++;
            @(negedge clk);
        end
    endtask
    task automatic run(input vec_t v);
        sel = v.sel;
        slave_word = v.slave;
        slave_len = v.n;
        wr(2'd3, 32'h6);
        wr(2'd1, v.tx);
        sc = 0;
        mosi_cap = '0;
        viol = 0;
        wr(2'd0, {11'b0, 5'(v.n - 1), v.div, 4'b0, v.lb, 1'b0, v.sel, 1'b1});
        wait_idle(cyc);
        check("busy_cycles", cyc, v.exp_busy);
        rd(2'd2, d);
        check("rxdata", d, v.exp_rx);
        rd(2'd3, d);
        check("status_done", d, 32'h2);
        check("sclk_edges", sc, v.n);
        check("mosi_seq", mosi_cap, v.exp_mosi);
        check("unsel_idle", viol, 0);
    endtask
    initial begin
        vecs[0] = '{8'd0, 1'b0, 1'b0, 8, 32'hA5, 32'h3C, 32'h3C, 17, 32'hA5};
        vecs[1] = '{8'd3, 1'b1, 1'b0, 32, 32'hDEADBEEF, 32'h12345678, 32'h12345678, 260, 32'hDEADBEEF};
        vecs[2] = '{8'd1, 1'b0, 1'b0, 1, 32'h1, 32'h1, 32'h1, 6, 32'h1};
        vecs[3] = '{8'd0, 1'b1, 1'b0, 4, 32'h9, 32'h6, 32'h6, 9, 32'h9};
        vecs[4] = '{8'd2, 1'b0, 1'b0, 16, 32'hFFFFC3A1, 32'hBEEF, 32'hBEEF, 99, 32'hC3A1};
        vecs[5] = '{8'd0, 1'b0, 1'b1, 8, 32'h5A, 32'h0, LB_RX, 17, 32'h5A};
        bus.OPB_DI = '0;
        bus.OPB_ADDR = '0;
        bus.APP_RE = 1'b0;
        bus.APP_WE = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_pins", {27'b0, cs0_n, cs1_n, spi_clk, mosi0 | mosi1, irq}, 32'h18);
        rd(2'd0, d);
        check("rst_ctrl", d, 32'h400);
        rd(2'd1, d);
        check("rst_tx", d, 32'h0);
        rd(2'd2, d);
        check("rst_rx", d, 32'h0);
        rd(2'd3, d);
        check("rst_status", d, 32'h0);
        check("rst_do_hold", bus.OPB_DO, 32'h0);
        foreach (vecs[i]) run(vecs[i]);
        // IRQ lags DONE by one cycle and follows its W1C with the same lag
        wr(2'd3, 32'h6);
        sel = 1'b0;
        slave_len = 4;
        wr(2'd0, 32'h0003_0005);
        wait_idle(cyc);
        check("irq_lag", irq, 1'b0);
        @(negedge clk);
        check("irq_set", irq, 1'b1);
        wr(2'd3, 32'h2);
        @(negedge clk);
        check("irq_clear", irq, 1'b0);
        rd(2'd3, d);
        check("irq_status", d, 32'h0);
        wr(2'd3, 32'h6);
        slave_word = '0;
        slave_len = 16;
        wr(2'd1, 32'h1234);
        sc = 0;
        mosi_cap = '0;
        wr(2'd0, 32'h000F_0001);
        repeat (5) @(negedge clk);
        wr(2'd1, 32'hFF);
        wr(2'd0, 32'h000F_0001);
        wait_idle(cyc);
        repeat (40) @(negedge clk);
        check("ovr_no_second", {cs0_n, 31'(sc)}, {1'b1, 31'd16});
        check("ovr_mosi", mosi_cap, 32'h1234);
        rd(2'd3, d);
        check("ovr_status", d, 32'h6);
        rd(2'd1, d);
        check("ovr_tx_kept", d, 32'h1234);
        wr(2'd3, 32'h6);
        slave_len = 16;
        wr(2'd1, 32'hFFFF);
        sc = 0;
        wr(2'd0, 32'h000F_0101);
        cyc = 0;
        while (sc < 5 && cyc < 500) begin
            cyc++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_pins", {28'b0, cs0_n, cs1_n, spi_clk, mosi0}, 32'hC);
        rst = 1'b0;
        rd(2'd3, d);
        check("midrst_status", d, 32'h0);
        rd(2'd0, d);
        check("midrst_ctrl", d, 32'h400);
        run('{8'd0, 1'b0, 1'b0, 4, 32'hA, 32'h5, 32'h5, 9, 32'hA});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
